// File: rtl/eco32_core_jpu_jcr_ctrl.sv
// eco32_core_jpu_jcr_ctrl: init sweep and round-robin write arbitration for the JPU jump/syscall register banks
module eco32_core_jpu_jcr_ctrl #(
  parameter logic [31:0] INIT_DATAL = 32'h0000_0000,
  parameter logic [31:0] INIT_DATAH = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        r0_req,
  input  logic [1:0]  r0_wen,
  input  logic        r0_tid,
  input  logic [3:0]  r0_addr,
  input  logic [31:0] r0_dataL,
  input  logic [31:0] r0_dataH,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic [1:0]  r1_wen,
  input  logic        r1_tid,
  input  logic [3:0]  r1_addr,
  input  logic [31:0] r1_dataL,
  input  logic [31:0] r1_dataH,
  output logic        r1_ack,
  output logic [1:0]  jcr_wen,
  output logic        jcr_tid,
  output logic [3:0]  jcr_addr,
  output logic [31:0] jcr_dataL,
  output logic [31:0] jcr_dataH,
  output logic        o_ready,
  output logic        o_busy
);
  typedef enum logic {INIT, RUN} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  wen_q, wen_d;
  logic        tid_q, tid_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] dl_q, dl_d, dh_q, dh_d;
  logic        run, g0, g1;
  // ptr_q=0 favours port 0 when both request; a clear pulse blocks grants that cycle
  always_comb begin
    run = (state_q == RUN);
    g0  = run && !i_clr && r0_req && (!r1_req || !ptr_q);
    g1  = run && !i_clr && r1_req && (!r0_req || ptr_q);
    state_d = run ? (i_clr ? INIT : RUN) : (cnt_q == 5'd31 ? RUN : INIT);
    cnt_d   = run ? 5'd0 : cnt_q + 5'd1;
    ptr_d   = g0 ? 1'b1 : g1 ? 1'b0 : ptr_q;
    wen_d   = !run ? 2'b11 : g0 ? r0_wen : g1 ? r1_wen : 2'b00;
    tid_d   = !run ? cnt_q[4] : g0 ? r0_tid : g1 ? r1_tid : tid_q;
    addr_d  = !run ? cnt_q[3:0] : g0 ? r0_addr : g1 ? r1_addr : addr_q;
    dl_d    = !run ? INIT_DATAL : g0 ? r0_dataL : g1 ? r1_dataL : dl_q;
    dh_d    = !run ? INIT_DATAH : g0 ? r0_dataH : g1 ? r1_dataH : dh_q;
  end
  // state, sweep counter, arbitration pointer and the registered write bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      wen_q   <= '0;
      tid_q   <= 1'b0;
      addr_q  <= '0;
      dl_q    <= '0;
      dh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      tid_q   <= tid_d;
      addr_q  <= addr_d;
      dl_q    <= dl_d;
      dh_q    <= dh_d;
    end
  end
  assign r0_ack    = g0;
  assign r1_ack    = g1;
  assign jcr_wen   = wen_q;
  assign jcr_tid   = tid_q;
  assign jcr_addr  = addr_q;
  assign jcr_dataL = dl_q;
  assign jcr_dataH = dh_q;
  assign o_ready   = run;
  assign o_busy    = |wen_q;
endmodule

// File: tb/tb_eco32_core_jpu_jcr_ctrl.sv
// tb_eco32_core_jpu_jcr_ctrl: directed and random checks against a behavioural model
module tb_eco32_core_jpu_jcr_ctrl;
  localparam logic [31:0] IDL = 32'h1234_5678;
  localparam logic [31:0] IDH = 32'h9ABC_DEF0;
  logic clk = 1'b0, rst = 1'b1, i_clr = 1'b0;
  logic r0_req = 1'b0, r1_req = 1'b0, r0_tid = 1'b0, r1_tid = 1'b0;
  logic [1:0] r0_wen = '0, r1_wen = '0;
  logic [3:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_dataL = '0, r0_dataH = '0, r1_dataL = '0, r1_dataH = '0;
  logic r0_ack, r1_ack, jcr_tid, o_ready, o_busy;
  logic [1:0] jcr_wen;
  logic [3:0] jcr_addr;
  logic [31:0] jcr_dataL, jcr_dataH;
  int checks = 0, passed = 0, fails = 0;
  bit m_init;
  int m_idx, m_last;
  logic [1:0] m_wen;
  logic m_tid;
  logic [3:0] m_addr;
  logic [31:0] m_dl, m_dh;
  bit got0, got1;

  eco32_core_jpu_jcr_ctrl #(.INIT_DATAL(IDL), .INIT_DATAH(IDH)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .r0_req(r0_req), .r0_wen(r0_wen), .r0_tid(r0_tid), .r0_addr(r0_addr),
    .r0_dataL(r0_dataL), .r0_dataH(r0_dataH), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_wen(r1_wen), .r1_tid(r1_tid), .r1_addr(r1_addr),
    .r1_dataL(r1_dataL), .r1_dataH(r1_dataH), .r1_ack(r1_ack),
    .jcr_wen(jcr_wen), .jcr_tid(jcr_tid), .jcr_addr(jcr_addr),
    .jcr_dataL(jcr_dataL), .jcr_dataH(jcr_dataH), .o_ready(o_ready), .o_busy(o_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_idx = 0; m_last = 1;
    m_wen = '0; m_tid = 0; m_addr = '0; m_dl = '0; m_dh = '0;
  endtask

  task automatic step();
    bit e0, e1;
    @(negedge clk);
    e0 = !m_init && !i_clr && r0_req && (!r1_req || m_last == 1);
    e1 = !m_init && !i_clr && r1_req && !e0;
    chk("ack0", 32'(r0_ack), 32'(e0));
    chk("ack1", 32'(r1_ack), 32'(e1));
    chk("ready", 32'(o_ready), 32'(!m_init));
    chk("busy", 32'(o_busy), 32'(m_wen != 0));
    chk("wen", 32'(jcr_wen), 32'(m_wen));
    chk("entry", {27'd0, jcr_tid, jcr_addr}, {27'd0, m_tid, m_addr});
    chk("dataL", jcr_dataL, m_dl);
    chk("dataH", jcr_dataH, m_dh);
    got0 = e0; got1 = e1;
    @(posedge clk);
    if (m_init) begin
      m_wen = 2'b11; {m_tid, m_addr} = 5'(m_idx); m_dl = IDL; m_dh = IDH;
      m_idx++;
      if (m_idx == 32) m_init = 0;
    end else if (e0) begin
      m_wen = r0_wen; m_tid = r0_tid; m_addr = r0_addr; m_dl = r0_dataL; m_dh = r0_dataH; m_last = 0;
    end else if (e1) begin
      m_wen = r1_wen; m_tid = r1_tid; m_addr = r1_addr; m_dl = r1_dataL; m_dh = r1_dataH; m_last = 1;
    end else m_wen = 2'b00;
    if (!m_init && i_clr && !e0 && !e1 && m_idx == 32 && m_wen == 2'b00 && 0) m_init = 1;
    #1;
  endtask

  task automatic clr_step();
    bit was_run;
    was_run = !m_init;
    i_clr = 1;
    step();
    i_clr = 0;
    if (was_run) begin m_init = 1; m_idx = 0; end
  endtask

  task automatic rnd0();
    r0_req = 1'($urandom); r0_wen = 2'($urandom); r0_tid = 1'($urandom); r0_addr = 4'($urandom);
    r0_dataL = $urandom; r0_dataH = $urandom;
  endtask

  task automatic rnd1();
    r1_req = 1'($urandom); r1_wen = 2'($urandom); r1_tid = 1'($urandom); r1_addr = 4'($urandom);
    r1_dataL = $urandom; r1_dataH = $urandom;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (33) step();
    r0_req = 1; r0_wen = 2'b01; r0_tid = 1; r0_addr = 4'd5; r0_dataL = 32'hDEAD_BEEF; r0_dataH = 32'h0BAD_F00D;
    step();
    chk("p0_ack", 32'(got0), 32'd1);
    r0_req = 0;
    step();
    chk("p0_dataL", jcr_dataL, 32'hDEAD_BEEF);
    step();
    r1_req = 1; r1_wen = 2'b00; r1_tid = 0; r1_addr = 4'd9; r1_dataL = $urandom; r1_dataH = $urandom;
    step();
    chk("p1_wen0_ack", 32'(got1), 32'd1);
    r1_req = 0;
    step();
    rnd0(); rnd1(); r0_req = 1; r1_req = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt", 32'(got0), 32'(i % 2 == 0));
      if (got0) rnd0();
      if (got1) rnd1();
      r0_req = 1; r1_req = 1;
    end
    r0_req = 0; r1_req = 0;
    step(); step();
    r0_req = 1; r0_wen = 2'b10; r0_tid = 0; r0_addr = 4'd3; r0_dataH = $urandom;
    clr_step();
    repeat (32) step();
    step();
    chk("clr_ack", 32'(got0), 32'd1);
    r0_req = 0;
    step();
    clr_step();
    while (m_idx < 17) step();
    rst = 1;
    model_reset();
    #2;
    chk("rst_wen", 32'(jcr_wen), 32'd0);
    chk("rst_entry", {27'd0, jcr_tid, jcr_addr}, 32'd0);
    chk("rst_dataL", jcr_dataL, 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    repeat (33) step();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0 && !m_init) clr_step();
      else step();
      if (!r0_req || got0) rnd0();
      if (!r1_req || got1) rnd1();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
